// File: rtl/bus_slave_pkg.sv
// Shared types and constants for the bus_slave_mem request/ack target.
package bus_slave_pkg;

    // Transaction sequencing: accept, optional wait states, ack pulse, idle gap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    // Width of the readable transaction counter.
    localparam int CNT_W = 16;

endpackage

// File: rtl/bus_slave_decode.sv
// Address decode for bus_slave_mem: counter register, memory word or error.
module bus_slave_decode #(
    parameter int              ADDR_W   = 32,
    parameter int              DEPTH    = 16,
    parameter int              IDX_W    = $clog2(DEPTH),
    parameter logic [ADDR_W-1:0] CNT_ADDR = 32'hFFFF_FFF0
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_mem_o,
    output logic              hit_cnt_o,
    output logic              err_o,
    output logic [IDX_W-1:0]  idx_o
);

    // Classify the captured address; the counter address takes priority.
    always_comb begin
        hit_cnt_o = (addr_i == CNT_ADDR);
        hit_mem_o = 1'b0;
        if (!hit_cnt_o && (addr_i[1:0] == 2'b00) && ((addr_i >> (IDX_W + 2)) == '0)) begin
            hit_mem_o = 1'b1;
        end else begin
            hit_mem_o = 1'b0;
        end
        err_o = ~(hit_cnt_o | hit_mem_o);
        idx_o = addr_i[IDX_W+1:2];
    end

endmodule

// File: rtl/bus_slave_mem.sv
// Req/ack bus slave with register-file storage, programmable wait states,
// decode error reporting and a readable 16-bit transaction counter.
module bus_slave_mem
    import bus_slave_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 16,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] CNT_ADDR    = 32'hFFFF_FFF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_e              state_q;
    logic [3:0]          wait_q;
    logic                cmd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                ack_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                dec_hit_mem;
    logic                dec_hit_cnt;
    logic                dec_err;
    logic [IDX_W-1:0]    dec_idx;
    logic [CNT_W-1:0]    cnt_d;
    logic [DATA_W-1:0]   rdata_d;
    logic                err_d;
    logic                mem_we;

    bus_slave_decode #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .CNT_ADDR (CNT_ADDR)
    ) u_decode (
        .addr_i    (addr_q),
        .hit_mem_o (dec_hit_mem),
        .hit_cnt_o (dec_hit_cnt),
        .err_o     (dec_err),
        .idx_o     (dec_idx)
    );

    // Response values and counter update for the transaction being acknowledged.
    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
        if (dec_hit_cnt) begin
            if (cmd_q == CMD_WR) begin
                cnt_d = '0;
            end else begin
                rdata_d = DATA_W'(cnt_q);
            end
        end else if (dec_hit_mem) begin
            if (cmd_q == CMD_WR) begin
                mem_we = 1'b1;
            end else begin
                rdata_d = mem_q[dec_idx];
            end
        end else begin
            err_d = dec_err;
        end
    end

    // Transaction FSM with registered response outputs, counter and memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            cmd_q   <= CMD_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (req) begin
                        cmd_q   <= cmd;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        wait_q  <= WAIT_LOAD;
                        state_q <= (WAIT_CYCLES > 0) ? WAIT : ACK;
                    end
                end
                WAIT: begin
                    if (wait_q == 4'd0) begin
                        state_q <= ACK;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b1;
                    err_q   <= err_d;
                    rdata_q <= rdata_d;
                    cnt_q   <= cnt_d;
                    if (mem_we) begin
                        mem_q[dec_idx] <= wdata_q;
                    end
                    state_q <= GAP;
                end
                GAP: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem: one instance with one wait state, one with none.
module tb_bus_slave_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        req1, cmd1, ack1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        req0, cmd0, ack0, err0;
    logic [31:0] addr0, wdata0, rdata0;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] CNT_A = 32'hFFFF_FFF0;

    always #5 clk = ~clk;

    bus_slave_mem #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .req(req1), .cmd(cmd1), .addr(addr1),
        .wdata(wdata1), .ack(ack1), .err(err1), .rdata(rdata1));

    bus_slave_mem #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req(req0), .cmd(cmd0), .addr(addr0),
        .wdata(wdata0), .ack(ack0), .err(err0), .rdata(rdata0));

    // One transaction on the selected instance; lat = edges after acceptance until ack is seen.
    task automatic txn(input bit sel, input logic c, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic e, output logic [31:0] rd);
        @(negedge clk);
        if (sel) begin req1 = 1'b1; cmd1 = c; addr1 = a; wdata1 = d; end
        else     begin req0 = 1'b1; cmd0 = c; addr0 = a; wdata0 = d; end
        @(posedge clk);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat = k;
            if ((sel ? ack1 : ack0) === 1'b1) break;
            lat = 20;
        end
        e  = sel ? err1 : err0;
        rd = sel ? rdata1 : rdata0;
        if (sel) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic test_reset();
        int lat; logic e; logic [31:0] rd; int acks;
        rst = 1'b0; req1 = 1'b0; req0 = 1'b0;
        cmd1 = 1'b0; cmd0 = 1'b0; addr1 = '0; addr0 = '0; wdata1 = '0; wdata0 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b expected 0", ack1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err1: got %b expected 0", err1); end
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h expected 0", rdata1); end
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b expected 0", ack0); end
        // Start a write, then reset while it sits in WAIT.
        req1 = 1'b1; cmd1 = 1'b1; addr1 = 32'h4; wdata1 = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({ack1, err1} !== 2'b00) begin errors++; $display("FAIL reset_mid_wait_flags: got %b expected 00", {ack1, err1}); end
        rst = 1'b1;
        acks = 0;
        repeat (5) begin @(negedge clk); if (ack1 === 1'b1) acks++; end
        checks++; if (acks != 0) begin errors++; $display("FAIL reset_abandon_ack: got %0d acks expected 0", acks); end
        txn(1'b1, 1'b0, 32'h4, 32'h0, lat, e, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_no_write: got %h expected 00000000", rd); end
        checks++; if (lat != 2) begin errors++; $display("FAIL reset_read_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_write_read();
        int lat; logic e; logic [31:0] rd;
        txn(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, lat, e, rd);
        checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h expected 00000000", rd); end
        @(negedge clk);
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b expected 0", ack1); end
        txn(1'b1, 1'b0, 32'h8, 32'h0, lat, e, rd);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_after_wr: got %h expected deadbeef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", e); end
    endtask

    task automatic test_back_to_back();
        int lat; logic e; logic [31:0] rd; int acks;
        txn(1'b0, 1'b1, 32'hC, 32'hA5A5_0F0F, lat, e, rd);
        checks++; if (lat != 1) begin errors++; $display("FAIL w0_latency: got %0d expected 1", lat); end
        @(negedge clk);
        req0 = 1'b1; cmd0 = 1'b0; addr0 = 32'hC;
        acks = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (ack0 !== ((k % 3) == 1)) begin
                errors++; $display("FAIL b2b_ack[%0d]: got %b expected %b", k, ack0, ((k % 3) == 1));
            end
            if (ack0 === 1'b1) begin
                acks++;
                checks++;
                if (rdata0 !== 32'hA5A5_0F0F) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected a5a50f0f", k, rdata0); end
            end
        end
        req0 = 1'b0;
        checks++; if (acks != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", acks); end
    endtask

    task automatic test_errors();
        int lat; logic e; logic [31:0] rd;
        txn(1'b1, 1'b0, 32'h2, 32'h0, lat, e, rd);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h expected 00000000", rd); end
        checks++; if (lat != 2) begin errors++; $display("FAIL misalign_latency: got %0d expected 2", lat); end
        txn(1'b1, 1'b1, 32'h40, 32'h5555_5555, lat, e, rd);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_wr_err: got %b expected 1", e); end
        txn(1'b1, 1'b0, 32'h0, 32'h0, lat, e, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL range_no_alias: got %h expected 00000000", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL addr0_err: got %b expected 0", e); end
        txn(1'b1, 1'b0, 32'h1000_0008, 32'h0, lat, e, rd);
        checks++; if ({e, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL high_addr: got err=%b rdata=%h expected err=1 rdata=00000000", e, rd); end
    endtask

    task automatic test_counter();
        int lat; logic e; logic [31:0] rd;
        // u_w0 has completed one write and four reads since reset.
        txn(1'b0, 1'b0, CNT_A, 32'h0, lat, e, rd);
        checks++; if (rd !== 32'd5) begin errors++; $display("FAIL cnt_read5: got %0d expected 5", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL cnt_err: got %b expected 0", e); end
        txn(1'b0, 1'b1, CNT_A, 32'hFFFF_FFFF, lat, e, rd);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL cnt_clr_err: got %b expected 0", e); end
        txn(1'b0, 1'b0, CNT_A, 32'h0, lat, e, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL cnt_after_clear: got %0d expected 0", rd); end
        @(negedge clk);
        force u_w0.cnt_q = 16'hFFFF;
        @(negedge clk);
        release u_w0.cnt_q;
        txn(1'b0, 1'b0, CNT_A, 32'h0, lat, e, rd);
        checks++; if (rd !== 32'h0000_FFFF) begin errors++; $display("FAIL cnt_pre_wrap: got %h expected 0000ffff", rd); end
        txn(1'b0, 1'b0, CNT_A, 32'h0, lat, e, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL cnt_wrap: got %h expected 00000000", rd); end
    endtask

    task automatic test_capture();
        int lat; logic e; logic [31:0] rd; int acks; logic ack_err;
        @(negedge clk);
        req1 = 1'b1; cmd1 = 1'b1; addr1 = 32'h10; wdata1 = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0; cmd1 = 1'b0; addr1 = 32'h14; wdata1 = 32'h0000_0BAD;
        acks = 0; ack_err = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (ack1 === 1'b1) begin acks++; ack_err = err1; end
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL capture_ack_count: got %0d expected 1", acks); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL capture_err: got %b expected 0", ack_err); end
        txn(1'b1, 1'b0, 32'h10, 32'h0, lat, e, rd);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL capture_orig: got %h expected cafef00d", rd); end
        txn(1'b1, 1'b0, 32'h14, 32'h0, lat, e, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL capture_other: got %h expected 00000000", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_errors();
        test_counter();
        test_capture();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
